// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: opcode values and FSM state type.
package mem_access_unit_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADR = 4'b1100;
    localparam logic [OP_W-1:0] OP_LDR = 4'b1101;
    localparam logic [OP_W-1:0] OP_STR = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } mau_state_e;

endpackage

// File: rtl/mau_wait_counter.sv
// Loadable down-counter that paces the RAM read latency.
// Ports: clk, rst_n; load/load_val preset the count; dec decrements it;
//        count_q is the current value; zero_c flags a count of zero.
module mau_wait_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count_q,
    output logic             zero_c
);

    logic [CNT_W-1:0] count_d;

    // Load takes priority; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: runs one ADR/LDR/STR/ALU-pass-through command at a time,
// strobing the RAM and producing a register write-back with a done pulse.
// Ports: clk, rst_n; start/op_code/SR1/SR2/ALU_result/IV_Mov command inputs;
//        RAM_out read data; busy/done/reg_we/reg_data status and write-back;
//        mem_re/mem_we/address_out/RAM_in RAM interface. All outputs registered.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OP_W-1:0]   op_code,
    input  logic [DATA_W-1:0] SR1,
    input  logic [DATA_W-1:0] SR2,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic [IMM_W-1:0]  IV_Mov,
    input  logic [DATA_W-1:0] RAM_out,
    output logic              busy,
    output logic              done,
    output logic              reg_we,
    output logic [DATA_W-1:0] reg_data,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] address_out,
    output logic [DATA_W-1:0] RAM_in
);

    localparam int unsigned CNT_W = $clog2(RD_LAT) + 1;

    mau_state_e state_q, state_d;

    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [IMM_W-1:0]  imm_q, imm_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              reg_we_q, reg_we_d;
    logic [DATA_W-1:0] reg_data_q, reg_data_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] ram_in_q, ram_in_d;

    logic              cnt_load, cnt_dec, cnt_zero_c;
    logic [CNT_W-1:0]  cnt_q;

    // Upper SR2 bits are dropped by address truncation.
    logic unused_sr2;
    assign unused_sr2 = ^SR2;

    // Read-latency counter: preset while leaving ISSUE, counts down in WAIT.
    assign cnt_load = (state_q == ST_ISSUE) && (op_q == OP_LDR);
    assign cnt_dec  = (state_q == ST_WAIT) && !cnt_zero_c;

    mau_wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (CNT_W'(RD_LAT - 1)),
        .dec      (cnt_dec),
        .count_q  (cnt_q),
        .zero_c   (cnt_zero_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_ISSUE;
            ST_ISSUE: state_d = (op_q == OP_LDR) ? ST_WAIT : ST_DONE;
            ST_WAIT:  if (cnt_zero_c) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic. Registered outputs are computed from the transition so
    // that each strobe is visible during the state it belongs to: RAM strobes
    // are set on acceptance (seen in ISSUE), done/write-back on entry to DONE.
    always_comb begin
        op_d       = op_q;
        alu_d      = alu_q;
        imm_d      = imm_q;
        busy_d     = (state_d != ST_IDLE);
        done_d     = 1'b0;
        reg_we_d   = 1'b0;
        reg_data_d = reg_data_q;
        mem_re_d   = 1'b0;
        mem_we_d   = 1'b0;
        addr_d     = addr_q;
        ram_in_d   = ram_in_q;

        if ((state_q == ST_IDLE) && start) begin
            op_d  = op_code;
            alu_d = ALU_result;
            imm_d = IV_Mov;
            unique case (op_code)
                OP_ADR: begin
                    mem_we_d = 1'b1;
                    addr_d   = SR1[ADDR_W-1:0];
                    ram_in_d = DATA_W'(IV_Mov);
                end
                OP_STR: begin
                    mem_we_d = 1'b1;
                    addr_d   = SR2[ADDR_W-1:0];
                    ram_in_d = SR1;
                end
                OP_LDR: begin
                    mem_re_d = 1'b1;
                    addr_d   = SR1[ADDR_W-1:0];
                end
                default: ;
            endcase
        end

        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            done_d = 1'b1;
            unique case (op_q)
                OP_ADR: begin
                    reg_we_d   = 1'b1;
                    reg_data_d = DATA_W'(imm_q);
                end
                OP_LDR: begin
                    reg_we_d   = 1'b1;
                    reg_data_d = RAM_out;
                end
                OP_STR: ;
                default: begin
                    reg_we_d   = 1'b1;
                    reg_data_d = alu_q;
                end
            endcase
        end
    end

    // Output and command registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            alu_q      <= '0;
            imm_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            reg_we_q   <= 1'b0;
            reg_data_q <= '0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_q     <= '0;
            ram_in_q   <= '0;
        end else begin
            op_q       <= op_d;
            alu_q      <= alu_d;
            imm_q      <= imm_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            reg_we_q   <= reg_we_d;
            reg_data_q <= reg_data_d;
            mem_re_q   <= mem_re_d;
            mem_we_q   <= mem_we_d;
            addr_q     <= addr_d;
            ram_in_q   <= ram_in_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign reg_we      = reg_we_q;
    assign reg_data    = reg_data_q;
    assign mem_re      = mem_re_q;
    assign mem_we      = mem_we_q;
    assign address_out = addr_q;
    assign RAM_in      = ram_in_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (default parameters, RD_LAT=2).
// Cycle n is the clock period following the n-th rising edge after start is sampled.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  op_code;
    logic [31:0] SR1, SR2, ALU_result, RAM_out;
    logic [15:0] IV_Mov;
    logic        busy, done, reg_we, mem_re, mem_we;
    logic [31:0] reg_data, RAM_in;
    logic [15:0] address_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op_code     (op_code),
        .SR1         (SR1),
        .SR2         (SR2),
        .ALU_result  (ALU_result),
        .IV_Mov      (IV_Mov),
        .RAM_out     (RAM_out),
        .busy        (busy),
        .done        (done),
        .reg_we      (reg_we),
        .reg_data    (reg_data),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .address_out (address_out),
        .RAM_in      (RAM_in)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and step past the accepting edge (now in cycle 1).
    task automatic launch(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [31:0] alu, input logic [15:0] imm);
        op_code = op; SR1 = s1; SR2 = s2; ALU_result = alu; IV_Mov = imm;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_tests++; if ({busy, done, reg_we, mem_re, mem_we} !== 5'b0) begin n_fail++;
            $display("FAIL reset_strobes: got %b expected 00000", {busy, done, reg_we, mem_re, mem_we}); end
        n_tests++; if (reg_data !== 32'h0) begin n_fail++;
            $display("FAIL reset_reg_data: got %h expected 0", reg_data); end
        n_tests++; if ({address_out, RAM_in} !== 48'h0) begin n_fail++;
            $display("FAIL reset_addr_ramin: got %h/%h expected 0/0", address_out, RAM_in); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        launch(4'b0010, 32'h1111, 32'h2222, 32'd5, 16'h0);
        n_tests++; if ({busy, done, mem_re, mem_we} !== 4'b1000) begin n_fail++;
            $display("FAIL alu_c1: busy/done/re/we got %b expected 1000", {busy, done, mem_re, mem_we}); end
        tick();
        n_tests++; if ({done, reg_we, mem_re, mem_we} !== 4'b1100) begin n_fail++;
            $display("FAIL alu_c2: done/we/re/mwe got %b expected 1100", {done, reg_we, mem_re, mem_we}); end
        n_tests++; if (reg_data !== 32'd5) begin n_fail++;
            $display("FAIL alu_data: got %h expected 00000005", reg_data); end
        tick();
        n_tests++; if ({busy, done} !== 2'b00) begin n_fail++;
            $display("FAIL alu_c3: busy/done got %b expected 00", {busy, done}); end
    endtask

    task automatic test_str();
        launch(4'b1110, 32'hDEADBEEF, 32'h0040, 32'h99, 16'h7777);
        n_tests++; if ({mem_we, mem_re, done} !== 3'b100) begin n_fail++;
            $display("FAIL str_c1_strobes: got %b expected 100", {mem_we, mem_re, done}); end
        n_tests++; if (address_out !== 16'h0040 || RAM_in !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL str_c1_bus: got %h/%h expected 0040/deadbeef", address_out, RAM_in); end
        tick();
        n_tests++; if ({done, reg_we, mem_we} !== 3'b100) begin n_fail++;
            $display("FAIL str_c2: done/reg_we/mem_we got %b expected 100", {done, reg_we, mem_we}); end
        n_tests++; if (reg_data !== 32'd5) begin n_fail++;
            $display("FAIL str_reg_hold: got %h expected 00000005", reg_data); end
        tick();
    endtask

    task automatic test_adr();
        // Upper SR1 bits must be dropped from the address.
        launch(4'b1100, 32'h12340010, 32'h0, 32'h0, 16'hABCD);
        n_tests++; if ({mem_we, mem_re} !== 2'b10) begin n_fail++;
            $display("FAIL adr_c1_strobes: got %b expected 10", {mem_we, mem_re}); end
        n_tests++; if (address_out !== 16'h0010 || RAM_in !== 32'h0000ABCD) begin n_fail++;
            $display("FAIL adr_c1_bus: got %h/%h expected 0010/0000abcd", address_out, RAM_in); end
        tick();
        n_tests++; if ({done, reg_we} !== 2'b11 || reg_data !== 32'h0000ABCD) begin n_fail++;
            $display("FAIL adr_done: done/we %b data %h expected 11 0000abcd", {done, reg_we}, reg_data); end
        tick();
        n_tests++; if (address_out !== 16'h0010 || RAM_in !== 32'h0000ABCD) begin n_fail++;
            $display("FAIL adr_hold: got %h/%h expected 0010/0000abcd", address_out, RAM_in); end
    endtask

    task automatic test_ldr();
        RAM_out = 32'h11111111;
        launch(4'b1101, 32'h0040, 32'h0, 32'h0, 16'h0);
        n_tests++; if ({mem_re, mem_we} !== 2'b10 || address_out !== 16'h0040) begin n_fail++;
            $display("FAIL ldr_c1: re/we %b addr %h expected 10 0040", {mem_re, mem_we}, address_out); end
        tick();
        n_tests++; if ({mem_re, done, busy} !== 3'b001) begin n_fail++;
            $display("FAIL ldr_c2: re/done/busy got %b expected 001", {mem_re, done, busy}); end
        tick();
        RAM_out = 32'hDEADBEEF;
        n_tests++; if (done !== 1'b0) begin n_fail++;
            $display("FAIL ldr_c3_done: got %b expected 0", done); end
        tick();
        RAM_out = 32'h22222222;
        n_tests++; if ({done, reg_we} !== 2'b11 || reg_data !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL ldr_c4: done/we %b data %h expected 11 deadbeef", {done, reg_we}, reg_data); end
        n_tests++; if (address_out !== 16'h0040) begin n_fail++;
            $display("FAIL ldr_addr_hold: got %h expected 0040", address_out); end
        tick();
        n_tests++; if ({busy, done, reg_we} !== 3'b000 || reg_data !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL ldr_c5: busy/done/we %b data %h expected 000 deadbeef", {busy, done, reg_we}, reg_data); end
    endtask

    task automatic test_reset_mid_read();
        int dones = 0;
        RAM_out = 32'h0;
        launch(4'b1101, 32'h0080, 32'h0, 32'h0, 16'h0);
        tick();
        rst_n = 1'b0;
        #1;
        n_tests++; if ({busy, done, reg_we, mem_re, mem_we} !== 5'b0 || reg_data !== 32'h0
                       || address_out !== 16'h0 || RAM_in !== 32'h0) begin n_fail++;
            $display("FAIL rst_mid_async: strobes %b data %h addr %h ramin %h expected all 0",
                     {busy, done, reg_we, mem_re, mem_we}, reg_data, address_out, RAM_in); end
        RAM_out = 32'hDEADBEEF;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        n_tests++; if (dones !== 0 || reg_data !== 32'h0 || busy !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_aborted: dones %0d data %h busy %b expected 0 0 0", dones, reg_data, busy); end
        launch(4'b1110, 32'h0BADF00D, 32'h0021, 32'h0, 16'h0);
        n_tests++; if (mem_we !== 1'b1 || address_out !== 16'h0021 || RAM_in !== 32'h0BADF00D) begin n_fail++;
            $display("FAIL rst_mid_str_c1: we %b addr %h ramin %h expected 1 0021 0badf00d", mem_we, address_out, RAM_in); end
        tick();
        n_tests++; if ({done, reg_we} !== 2'b10) begin n_fail++;
            $display("FAIL rst_mid_str_done: done/we got %b expected 10", {done, reg_we}); end
        tick();
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        RAM_out = 32'h0;
        op_code = 4'b1101; SR1 = 32'h0044; SR2 = 32'h0; ALU_result = 32'h0; IV_Mov = 16'h0;
        start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            // Input changes while busy must be ignored; the ALU op is taken only once idle.
            if (c == 2) begin op_code = 4'b0010; ALU_result = 32'd7; end
            if (c == 3) RAM_out = 32'hCAFEF00D;
            if (c == 4) RAM_out = 32'h0;
            if (c == 6) start = 1'b0;
            if (done === 1'b1) dones++;
            if (c == 4) begin
                n_tests++; if (done !== 1'b1 || reg_data !== 32'hCAFEF00D) begin n_fail++;
                    $display("FAIL b2b_first_done: done %b data %h expected 1 cafef00d", done, reg_data); end
            end
            if (c == 5) begin
                n_tests++; if ({busy, done} !== 2'b00) begin n_fail++;
                    $display("FAIL b2b_idle_gap: busy/done got %b expected 00", {busy, done}); end
            end
            if (c == 6) begin
                n_tests++; if ({busy, mem_re, mem_we} !== 3'b100) begin n_fail++;
                    $display("FAIL b2b_second_issue: busy/re/we got %b expected 100", {busy, mem_re, mem_we}); end
            end
            if (c == 7) begin
                n_tests++; if ({done, reg_we} !== 2'b11 || reg_data !== 32'd7) begin n_fail++;
                    $display("FAIL b2b_second_done: done/we %b data %h expected 11 00000007", {done, reg_we}, reg_data); end
            end
        end
        n_tests++; if (dones !== 2) begin n_fail++;
            $display("FAIL b2b_done_count: got %0d expected 2", dones); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op_code = 4'h0;
        SR1 = '0; SR2 = '0; ALU_result = '0; IV_Mov = '0; RAM_out = '0;
        test_reset();
        test_alu();
        test_str();
        test_adr();
        test_ldr();
        test_reset_mid_read();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, default 32, data path and register-file write width.
REQ-002 Parameter ADDR_W, default 16, RAM address width.
REQ-003 Parameter IMM_W, default 16, immediate (IV_Mov) width, IMM_W <= DATA_W.
REQ-004 Parameter RD_LAT, default 2, RAM read latency in cycles, 1..15.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 start  in  1  command valid, sampled only in IDLE.
REQ-008 op_code  in  4  1100 ADR, 1101 LDR, 1110 STR, other = ALU pass-through.
REQ-009 SR1, SR2  in  DATA_W each  source operands.
REQ-010 ALU_result  in  DATA_W  ALU output for pass-through.
REQ-011 IV_Mov  in  IMM_W  immediate.
REQ-012 RAM_out  in  DATA_W  RAM read data, valid RD_LAT cycles after mem_re.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 reg_we  out  1  register write strobe, coincident with done when op writes back.
REQ-016 reg_data  out  DATA_W  write-back value, held until next done.
REQ-017 mem_re, mem_we  out  1 each  RAM read/write strobes, one cycle each, never both high.
REQ-018 address_out  out  ADDR_W  RAM address, registered.
REQ-019 RAM_in  out  DATA_W  RAM write data, registered.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, DONE; encoding internal.
REQ-021 IDLE: start=1 latches op_code, SR1, SR2, ALU_result, IV_Mov; next state ISSUE.
REQ-022 ISSUE, ADR: mem_we=1, address_out=SR1[ADDR_W-1:0], RAM_in=zero-extended IV_Mov; next DONE.
REQ-023 ISSUE, STR: mem_we=1, address_out=SR2[ADDR_W-1:0], RAM_in=SR1; next DONE.
REQ-024 ISSUE, LDR: mem_re=1, address_out=SR1[ADDR_W-1:0]; wait counter loaded RD_LAT-1; next WAIT.
REQ-025 ISSUE, ALU op: no RAM strobe; next DONE.
REQ-026 WAIT: counter decrements each cycle; at zero RAM_out captured; next DONE.
REQ-027 DONE: done=1 one cycle; next IDLE; start accepted again the following cycle.
REQ-028 Write-back on done: ADR -> zero-extended IV_Mov; LDR -> captured RAM_out; ALU -> latched ALU_result; STR -> reg_we=0, reg_data unchanged.
REQ-029 Latency start-to-done: ALU 2, ADR/STR 2, LDR RD_LAT+2 cycles.
REQ-030 start while busy is ignored, not queued; inputs changing while busy have no effect.
REQ-031 Address truncation: SR bits above ADDR_W dropped, no error flag.
REQ-032 address_out and RAM_in hold last driven value outside ISSUE.

Reset
REQ-033 rst_n low forces IDLE immediately regardless of state, including WAIT mid-read.
REQ-034 Reset values: busy, done, reg_we, mem_re, mem_we = 0; reg_data, address_out, RAM_in, counter = 0.
REQ-035 A read aborted by reset produces no done and no write-back; RAM_out arriving later is ignored.

Structure
REQ-036 Shared package holds op_code constants (OP_ADR, OP_LDR, OP_STR) and FSM state type.
REQ-037 One sub-module, mau_wait_counter: loadable down-counter, width clog2(RD_LAT)+1, zero flag.

Verification
REQ-038 STR SR1=0xDEADBEEF, SR2=0x0040 -> cycle 1 mem_we=1, address_out=0x0040, RAM_in=0xDEADBEEF; done cycle 2, reg_we=0.
REQ-039 LDR SR1=0x0040, RD_LAT=2, RAM_out=0xDEADBEEF -> mem_re cycle 1, done+reg_we cycle 4, reg_data=0xDEADBEEF.
REQ-040 ADR IV_Mov=0xABCD, SR1=0x0010 -> mem_we, RAM_in=0x0000ABCD, address 0x0010; reg_data=0x0000ABCD at done.
REQ-041 ALU op 0010, ALU_result=5 -> no mem strobe, done cycle 2, reg_data=5.
REQ-042 LDR then rst_n low during WAIT -> all outputs 0 asynchronously, no done; next STR completes normally.
REQ-043 start held high across LDR -> exactly one done per accepted command, second command accepted cycle after done.
